// File: rtl/column_move_engine.sv
// Connect-Four board store with a go/done move-commit engine.
// Keeps per-column occupancy/owner masks, a landing row and a move counter.
module column_move_engine #(
    parameter int ROWS = 6,
    parameter int COLS = 7,
    parameter int CW   = 3,
    parameter int RW   = 3,
    parameter int MW   = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear_board,
    input  logic            go,
    input  logic [CW-1:0]   col_sel,
    input  logic            cur_player,
    output logic            busy,
    output logic            done,
    output logic            valid_move,
    output logic [RW-1:0]   land_row,
    output logic [MW-1:0]   move_count,
    output logic            board_full,
    input  logic [CW-1:0]   rd_col,
    output logic [ROWS-1:0] rd_onoff,
    output logic [ROWS-1:0] rd_player
);

    localparam int TOTAL = ROWS * COLS;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] FETCH  = 2'd1;
    localparam logic [1:0] COMMIT = 2'd2;
    localparam logic [1:0] REPORT = 2'd3;

    logic [1:0]      state;
    logic [CW-1:0]   col_q;
    logic            plr_q;
    logic [RW:0]     height_q;
    logic            ok_q;

    logic [ROWS-1:0] onoff  [COLS];
    logic [ROWS-1:0] player [COLS];

    logic [ROWS-1:0] sel_on;
    logic            sel_hit;
    logic [RW:0]     sel_cnt;
    logic            fetch_ok;
    logic            do_clear;

    assign do_clear   = (state == IDLE) && clear_board;
    assign busy       = (state != IDLE);
    assign done       = (state == REPORT);
    assign board_full = (move_count == MW'(TOTAL));

    // Height of the latched column; a missing column is never a valid target.
    always_comb begin
        sel_on  = '0;
        sel_hit = 1'b0;
        sel_cnt = '0;
        for (int c = 0; c < COLS; c++) begin
            if (col_q == CW'(c)) begin
                sel_on  = onoff[c];
                sel_hit = 1'b1;
            end
        end
        for (int r = 0; r < ROWS; r++) begin
            sel_cnt = sel_cnt + {{RW{1'b0}}, sel_on[r]};
        end
        fetch_ok = sel_hit && (sel_cnt < (RW+1)'(ROWS));
    end

    // Move sequencer: accept in IDLE, then FETCH, COMMIT, REPORT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            col_q    <= '0;
            plr_q    <= 1'b0;
            height_q <= '0;
            ok_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!clear_board && go) begin
                        col_q <= col_sel;
                        plr_q <= cur_player;
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    height_q <= sel_cnt;
                    ok_q     <= fetch_ok;
                    state    <= COMMIT;
                end
                COMMIT:  state <= REPORT;
                default: state <= IDLE;
            endcase
        end
    end

    // Board masks: wipe on clear, drop one piece on a valid commit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < COLS; c++) begin
                onoff[c]  <= '0;
                player[c] <= '0;
            end
        end else if (do_clear) begin
            for (int c = 0; c < COLS; c++) begin
                onoff[c]  <= '0;
                player[c] <= '0;
            end
        end else if (state == COMMIT && ok_q) begin
            for (int c = 0; c < COLS; c++) begin
                if (col_q == CW'(c)) begin
                    onoff[c] <= {onoff[c][ROWS-2:0], 1'b1};
                    for (int r = 0; r < ROWS; r++) begin
                        if (height_q == (RW+1)'(r)) begin
                            player[c][r] <= plr_q;
                        end
                    end
                end
            end
        end
    end

    // Move result, landing row and saturating move counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_move <= 1'b0;
            land_row   <= '0;
            move_count <= '0;
        end else if (do_clear) begin
            move_count <= '0;
        end else if (state == COMMIT) begin
            valid_move <= ok_q;
            if (ok_q) begin
                land_row <= height_q[RW-1:0];
                if (move_count != MW'(TOTAL)) begin
                    move_count <= move_count + 1'b1;
                end
            end
        end
    end

    // Combinational read port; out-of-range columns read as empty.
    always_comb begin
        rd_onoff  = '0;
        rd_player = '0;
        for (int c = 0; c < COLS; c++) begin
            if (rd_col == CW'(c)) begin
                rd_onoff  = onoff[c];
                rd_player = player[c];
            end
        end
    end

endmodule

// File: doc/column_move_engine.md
Name: column_move_engine

Overview:
- Registered Connect-Four board store with a move-commit engine.
- Holds an occupancy mask and an owner mask per column for a ROWS x COLS board.
- Accepts one move request at a time via a go/done handshake, validates it, and drops the piece into the lowest free row.
- Exposes a combinational read port for the display/win-check logic.
- Generalises the single-column validator to N columns with stored state, landing-row reporting and a move counter.

Parameters:
ROWS, 6, rows per column (board height), 2..16
COLS, 7, number of columns, 2..16
CW, 3, column-index width, must satisfy 2^CW >= COLS
RW, 3, row-index width, must satisfy 2^RW >= ROWS
MW, 6, move-counter width, must satisfy 2^MW > ROWS*COLS

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
clear_board  in  1  synchronous board wipe; honoured only in IDLE
go  in  1  move request; sampled only in IDLE
col_sel  in  CW  target column for the move
cur_player  in  1  owner of the dropped piece (0 or 1)
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse when a move completes
valid_move  out  1  result of the last move; held until the next done
land_row  out  RW  row written by the last valid move; held
move_count  out  MW  number of valid moves since reset or clear
board_full  out  1  high when move_count == ROWS*COLS
rd_col  in  CW  read-port column index
rd_onoff  out  ROWS  occupancy of column rd_col, bit0 = bottom
rd_player  out  ROWS  owner bits of column rd_col, meaningful only where rd_onoff=1

Behaviour:
- Reset (async, immediate):
  - All occupancy and owner masks = 0.
  - FSM = IDLE; busy = 0, done = 0, valid_move = 0, land_row = 0, move_count = 0, board_full = 0.
  - Reset mid-move aborts the move with no write.
- FSM states IDLE, FETCH, COMMIT, REPORT.
  - IDLE:
    - If clear_board = 1: masks and move_count go to 0 next cycle, and clear takes priority over go.
    - Else if go = 1: latch col_sel and cur_player, go to FETCH.
    - go while busy is ignored, not queued.
  - FETCH:
    - Read the latched column and compute height = popcount of its occupancy.
    - Occupancy is always a thermometer code from bit 0.
    - ok = (col < COLS) and (height < ROWS).
    - Go to COMMIT.
  - COMMIT:
    - If ok: onoff[col] <= (onoff << 1) | 1; player[col] bit[height] <= cur_player, with other bits unchanged. An explicit clear is required when cur_player = 0.
    - If ok: land_row <= height and move_count += 1.
    - If not ok: no state change except valid_move <= 0. land_row keeps its prior value.
    - valid_move <= ok. Go to REPORT.
  - REPORT: done = 1 for exactly this cycle, then IDLE.
- Latency and throughput:
  - go accepted at edge N, done high during cycle N+3.
  - Back-to-back: the next go is accepted on the edge after REPORT, giving 4 cycles per move.
- move_count saturates at ROWS*COLS. Only valid moves can increment it, so it never wraps.
- board_full is combinational from move_count. It does not block go; moves when full simply return valid_move = 0.
- Read port:
  - Purely combinational from stored masks; no read latency.
  - rd_col >= COLS returns all zeros.
  - The read reflects the COMMIT write starting the cycle after the COMMIT edge.
- Never write a column index >= COLS. Out-of-range col_sel is an invalid move, not a wrap.

Test Plan:
- Reset, then go col=3, player=1 → done at cycle+3, valid=1, land_row=0, rd_col=3 gives onoff=000001 and player=000001, move_count=1.
- Six alternating moves into col 0 (p=1,0,1,0,1,0) → land_row 0..5 in order, onoff=111111, player=010101. A seventh move into col 0 → valid=0, masks unchanged, move_count=6.
- col_sel=7 with COLS=7 → valid=0, no column changes, land_row unchanged.
- Fill all 42 cells → board_full=1, move_count=42. A further go → valid=0, count stays 42. Then clear_board in IDLE → all rd columns 0, count=0, board_full=0.
- go pulsed during FETCH/COMMIT → ignored; exactly one done. clear_board and go in the same IDLE cycle → board cleared, no move performed.
- Assert reset during COMMIT → outputs zero immediately, column unwritten, FSM in IDLE; a subsequent move behaves normally.
